// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
//
// Purpose: state encoding, register-index width, register-zero constant and
//          default multiply/divide latency used by pipe_hazard_ctrl.
// Ports:   none (package).
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      MDU_WAIT  = 2'd1,
      MDU_DRAIN = 2'd2
   } state_t;

   localparam int                   REG_IDX_W       = 5;
   localparam logic [REG_IDX_W-1:0] REG_ZERO        = '0;
   localparam int                   MDU_LAT_DEFAULT = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// rtl/pipe_hazard_ctrl_hazard_detect.sv - combinational load-use hazard detector
//
// Purpose: flags when the instruction in ID reads a register that the load
//          currently in EX will write, so ID must wait one cycle.
// Ports:
//   id_rs, id_rt          source register fields of the ID instruction
//   id_rs_used, id_rt_used  whether each source field is actually read
//   ex_load, ex_regwe     EX instruction is a load / writes a register
//   ex_wreg               EX destination register
//   lu                    load-use hazard present
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [REG_IDX_W-1:0] id_rs,
   input  logic [REG_IDX_W-1:0] id_rt,
   input  logic                 id_rs_used,
   input  logic                 id_rt_used,
   input  logic                 ex_load,
   input  logic                 ex_regwe,
   input  logic [REG_IDX_W-1:0] ex_wreg,
   output logic                 lu
);

   logic rs_hit;
   logic rt_hit;

   assign rs_hit = id_rs_used && (id_rs == ex_wreg);
   assign rt_hit = id_rt_used && (id_rt == ex_wreg);

   // r0 is hardwired to zero, so a load targeting it never creates a dependency.
   assign lu = ex_load && ex_regwe && (ex_wreg != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the five-stage pipeline
//
// Purpose: resolves taken branches (flush FI_ID/ID_EX), multi-cycle MDU
//          occupancy (pause front end for MDU_LAT cycles, then drain) and
//          load-use hazards (one-cycle front-end pause), and counts stalls.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   id_rs/id_rt/id_rs_used/id_rt_used  ID source operands
//   ex_load/ex_regwe/ex_wreg         EX load destination info
//   ex_mdu, ex_branch_taken          EX is mult/div, EX redirects PC
//   mdu_start                        one-cycle MDU operand latch pulse
//   pause_pc/pause_fi_id/pause_id_ex/pause_ex_mem/pause_mem_wb  stage holds
//   flush_fi_id, flush_id_ex         synchronous stage clears
//   busy                             sequencer is inside an MDU operation
//   stall_cnt                        saturating count of pause_pc cycles
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MDU_LAT = MDU_LAT_DEFAULT,
   parameter int CNT_W   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [REG_IDX_W-1:0] id_rs,
   input  logic [REG_IDX_W-1:0] id_rt,
   input  logic                 id_rs_used,
   input  logic                 id_rt_used,
   input  logic                 ex_load,
   input  logic                 ex_regwe,
   input  logic [REG_IDX_W-1:0] ex_wreg,
   input  logic                 ex_mdu,
   input  logic                 ex_branch_taken,
   output logic                 mdu_start,
   output logic                 pause_pc,
   output logic                 pause_fi_id,
   output logic                 pause_id_ex,
   output logic                 pause_ex_mem,
   output logic                 pause_mem_wb,
   output logic                 flush_fi_id,
   output logic                 flush_id_ex,
   output logic                 busy,
   output logic [CNT_W-1:0]     stall_cnt
);

   localparam int MCNT_W    = $clog2(MDU_LAT + 1);
   // The RUN start cycle is the first pause cycle, so WAIT covers MDU_LAT-1
   // cycles: mcnt runs from MDU_LAT-2 down to 0.
   localparam int MCNT_INIT = (MDU_LAT >= 2) ? (MDU_LAT - 2) : 0;

   state_t              state, state_nxt;
   logic [MCNT_W-1:0]   mcnt, mcnt_nxt;
   logic [CNT_W-1:0]    cnt;
   logic                lu;

   hazard_detect u_hazard_detect (
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_rs_used (id_rs_used),
      .id_rt_used (id_rt_used),
      .ex_load    (ex_load),
      .ex_regwe   (ex_regwe),
      .ex_wreg    (ex_wreg),
      .lu         (lu)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         mcnt  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         mcnt  <= mcnt_nxt;
         if (pause_pc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      mcnt_nxt     = mcnt;
      mdu_start    = 1'b0;
      pause_pc     = 1'b0;
      pause_fi_id  = 1'b0;
      pause_id_ex  = 1'b0;
      pause_ex_mem = 1'b0;
      pause_mem_wb = 1'b0;
      flush_fi_id  = 1'b0;
      flush_id_ex  = 1'b0;

      // Reset forces every output low in the same cycle, not just after the edge.
      if (!rst) begin
         case (state)
            RUN: begin
               if (ex_branch_taken) begin
                  flush_fi_id = 1'b1;
                  flush_id_ex = 1'b1;
               end else if (ex_mdu) begin
                  mdu_start   = 1'b1;
                  pause_pc    = 1'b1;
                  pause_fi_id = 1'b1;
                  pause_id_ex = 1'b1;
                  if (MDU_LAT == 1) begin
                     state_nxt = MDU_DRAIN;
                  end else begin
                     mcnt_nxt  = MCNT_W'(MCNT_INIT);
                     state_nxt = MDU_WAIT;
                  end
               end else if (lu) begin
                  // ID_EX keeps advancing, so it picks up the zeroed FI_ID
                  // output as a bubble behind the load.
                  pause_pc    = 1'b1;
                  pause_fi_id = 1'b1;
               end
            end
            MDU_WAIT: begin
               pause_pc    = 1'b1;
               pause_fi_id = 1'b1;
               pause_id_ex = 1'b1;
               if (mcnt == '0) begin
                  state_nxt = MDU_DRAIN;
               end else begin
                  mcnt_nxt = mcnt - 1'b1;
               end
            end
            MDU_DRAIN: begin
               // ex_mdu is still high here; ignoring it lets the finished op
               // leave EX instead of restarting.
               state_nxt = RUN;
            end
            default: begin
               state_nxt = RUN;
            end
         endcase
      end
   end

   assign busy      = !rst && (state != RUN);
   assign stall_cnt = rst ? '0 : cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

   localparam int LAT = 4;

   typedef struct packed {
      logic [8:0]  flags;
      logic [31:0] cnt_a;
      logic [2:0]  cnt_b;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] id_rs = '0, id_rt = '0, ex_wreg = '0;
   logic       id_rs_used = 1'b0, id_rt_used = 1'b0;
   logic       ex_load = 1'b0, ex_regwe = 1'b0, ex_mdu = 1'b0, ex_branch_taken = 1'b0;

   logic        a_start, a_ppc, a_pfi, a_pid, a_pem, a_pmw, a_ffi, a_fid, a_busy;
   logic [31:0] a_cnt;
   logic        b_start, b_ppc, b_pfi, b_pid, b_pem, b_pmw, b_ffi, b_fid, b_busy;
   logic [2:0]  b_cnt;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MDU_LAT(LAT), .CNT_W(32)) dut_a (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
      .ex_load(ex_load), .ex_regwe(ex_regwe), .ex_wreg(ex_wreg),
      .ex_mdu(ex_mdu), .ex_branch_taken(ex_branch_taken),
      .mdu_start(a_start), .pause_pc(a_ppc), .pause_fi_id(a_pfi),
      .pause_id_ex(a_pid), .pause_ex_mem(a_pem), .pause_mem_wb(a_pmw),
      .flush_fi_id(a_ffi), .flush_id_ex(a_fid), .busy(a_busy), .stall_cnt(a_cnt)
   );

   pipe_hazard_ctrl #(.MDU_LAT(LAT), .CNT_W(3)) dut_b (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
      .ex_load(ex_load), .ex_regwe(ex_regwe), .ex_wreg(ex_wreg),
      .ex_mdu(ex_mdu), .ex_branch_taken(ex_branch_taken),
      .mdu_start(b_start), .pause_pc(b_ppc), .pause_fi_id(b_pfi),
      .pause_id_ex(b_pid), .pause_ex_mem(b_pem), .pause_mem_wb(b_pmw),
      .flush_fi_id(b_ffi), .flush_id_ex(b_fid), .busy(b_busy), .stall_cnt(b_cnt)
   );

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   bit   done     = 1'b0;
   bit   drained  = 1'b0;

   // Reference model: pause cycles still owed to the current MDU op, whether
   // a drain cycle follows, and the two stall counts.
   int      m_pause_left = 0;
   bit      m_drain      = 1'b0;
   longint  m_cnt_a      = 0;
   int      m_cnt_b      = 0;

   task automatic step(input bit r, input bit br, input bit mdu, input bit ld,
                       input bit we, input int wreg, input int rs, input int rt,
                       input bit rsu, input bit rtu);
      bit s, ppc, pid, ffi, bsy, lu;
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; ex_branch_taken = br; ex_mdu = mdu; ex_load = ld; ex_regwe = we;
      ex_wreg = 5'(wreg); id_rs = 5'(rs); id_rt = 5'(rt);
      id_rs_used = rsu; id_rt_used = rtu;

      s = 0; ppc = 0; pid = 0; ffi = 0; bsy = 0;
      lu = ld && we && (wreg != 0) && ((rsu && rs == wreg) || (rtu && rt == wreg));
      if (r) begin
         // all zero
      end else if (m_pause_left > 0) begin
         ppc = 1; pid = 1; bsy = 1;
      end else if (m_drain) begin
         bsy = 1;
      end else if (br) begin
         ffi = 1;
      end else if (mdu) begin
         s = 1; ppc = 1; pid = 1;
      end else if (lu) begin
         ppc = 1;
      end
      e.flags = {s, ppc, ppc, pid, 1'b0, 1'b0, ffi, ffi, bsy};
      e.cnt_a = r ? 32'd0 : 32'(m_cnt_a);
      e.cnt_b = r ? 3'd0 : 3'(m_cnt_b);
      exp_q.push_back(e);

      if (r) begin
         m_pause_left = 0; m_drain = 0; m_cnt_a = 0; m_cnt_b = 0;
      end else begin
         if (m_pause_left > 0) begin
            m_pause_left--;
            if (m_pause_left == 0) m_drain = 1;
         end else if (m_drain) begin
            m_drain = 0;
         end else if (!br && mdu) begin
            m_pause_left = LAT - 1;
            if (m_pause_left == 0) m_drain = 1;
         end
         if (ppc) begin
            if (m_cnt_a < 64'hFFFF_FFFF) m_cnt_a++;
            if (m_cnt_b < 7) m_cnt_b++;
         end
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      int   cyc;
      cyc = int'($time / 10);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if ({a_start, a_ppc, a_pfi, a_pid, a_pem, a_pmw, a_ffi, a_fid, a_busy} !== e.flags) begin
            failures++;
            $display("FAIL flags_a cycle=%0d act=%b exp=%b", cyc,
                     {a_start, a_ppc, a_pfi, a_pid, a_pem, a_pmw, a_ffi, a_fid, a_busy}, e.flags);
         end
         checks++;
         if ({b_start, b_ppc, b_pfi, b_pid, b_pem, b_pmw, b_ffi, b_fid, b_busy} !== e.flags) begin
            failures++;
            $display("FAIL flags_b cycle=%0d act=%b exp=%b", cyc,
                     {b_start, b_ppc, b_pfi, b_pid, b_pem, b_pmw, b_ffi, b_fid, b_busy}, e.flags);
         end
         checks++;
         if (a_cnt !== e.cnt_a) begin
            failures++;
            $display("FAIL stall_cnt_32 cycle=%0d act=%0d exp=%0d", cyc, a_cnt, e.cnt_a);
         end
         checks++;
         if (b_cnt !== e.cnt_b) begin
            failures++;
            $display("FAIL stall_cnt_3 cycle=%0d act=%0d exp=%0d", cyc, b_cnt, e.cnt_b);
         end
      end else if (done && !drained) begin
         drained = 1'b1;
         checks++;
         if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain act=%0d exp=0", exp_q.size());
         end
      end
   end

   initial begin
      // reset
      step(1, 0,0,0,0,0,0,0,0,0);
      step(1, 0,0,0,0,0,0,0,0,0);
      // load-use on rs, then quiet
      step(0, 0,0,1,1,8,8,0,1,0);
      step(0, 0,0,0,0,0,0,0,0,0);
      // r0 destination, and matching rt that is not read
      step(0, 0,0,1,1,0,0,0,1,1);
      step(0, 0,0,1,1,9,0,9,0,0);
      // load-use on rt
      step(0, 0,0,1,1,5,1,5,1,1);
      // MDU held for the whole op plus one
      for (int i = 0; i < LAT + 2; i++) step(0, 0,1,0,0,0,0,0,0,0);
      step(0, 0,0,0,0,0,0,0,0,0);
      // back-to-back MDU ops
      for (int i = 0; i < 2 * (LAT + 1); i++) step(0, 0,1,0,0,0,0,0,0,0);
      step(0, 0,0,0,0,0,0,0,0,0);
      // branch beats load-use, and beats MDU start
      step(0, 1,0,1,1,8,8,0,1,0);
      step(0, 1,1,1,1,8,8,0,1,0);
      step(0, 0,0,0,0,0,0,0,0,0);
      // reset on the second wait cycle
      step(0, 0,1,0,0,0,0,0,0,0);
      step(0, 0,1,0,0,0,0,0,0,0);
      step(1, 0,1,0,0,0,0,0,0,0);
      step(0, 0,0,0,0,0,0,0,0,0);
      // saturation of the narrow counter
      for (int i = 0; i < 10; i++) step(0, 0,0,1,1,3,3,3,1,1);
      step(0, 0,0,0,0,0,0,0,0,0);
      // random traffic over a small register range to provoke collisions
      for (int i = 0; i < 500; i++) begin
         step(($urandom_range(0, 39) == 0),
              ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 7) == 0),
              bit'($urandom_range(0, 1)),
              bit'($urandom_range(0, 3) != 0),
              int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)),
              bit'($urandom_range(0, 1)),
              bit'($urandom_range(0, 1)));
      end
      @(posedge clk);
      #1;
      done = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
